sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-MM SDRAM master port between two requesters with round-robin arbitration.
- Requester 0 is the framebuffer write engine (pixel/gradient writer); requester 1 is the readback/display fetch path.
- Pipelined reads are supported: the ID of every accepted read is queued so each returning readdatavalid beat is routed to the requester that issued it.
- Sits between the custom master logic and the SDRAM controller's Avalon slave.

Parameters:
ADDRESSWIDTH, 26, width of all address buses
DATAWIDTH, 32, width of all data buses
MAX_PENDING, 4, maximum outstanding reads; depth of the read-ID FIFO (power of 2, ≥2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
r0_address  in  ADDRESSWIDTH  requester 0 address
r0_write  in  1  requester 0 write request
r0_read  in  1  requester 0 read request
r0_writedata  in  DATAWIDTH  requester 0 write data
r0_waitrequest  out  1  requester 0 stall; low means the transfer is accepted this cycle
r0_readdata  out  DATAWIDTH  requester 0 read data
r0_readdatavalid  out  1  requester 0 read data valid
r1_address, r1_write, r1_read, r1_writedata, r1_waitrequest, r1_readdata, r1_readdatavalid: same widths and meaning, requester 1
m_address  out  ADDRESSWIDTH  master address to SDRAM
m_write  out  1  master write
m_read  out  1  master read
m_writedata  out  DATAWIDTH  master write data
m_waitrequest  in  1  SDRAM stall
m_readdata  in  DATAWIDTH  SDRAM read data
m_readdatavalid  in  1  SDRAM read data valid
pending_count  out  $clog2(MAX_PENDING)+1  outstanding reads
err_unexpected_rdv  out  1  sticky; readdatavalid arrived with no read outstanding

Behaviour:
- Reset (synchronous, active-low; clk is the clock), and reset asserted mid-transfer:
  - state=ARB, last_grant=1, ID FIFO empty, pending_count=0, err_unexpected_rdv=0.
  - m_read=m_write=0, m_address=0, m_writedata=0.
  - Both rN_waitrequest=1, both rN_readdatavalid=0.
  - Any in-flight read data is lost to the requesters.
- Request definition: reqN = rN_write | rN_read.
  - A read request is eligible only when pending_count < MAX_PENDING. Writes are always eligible.
  - If rN_write and rN_read are both high, it is treated as a write and the read is ignored.
- State ARB:
  - Master outputs idle (all zero). Both rN_waitrequest=1.
  - If exactly one eligible requester: grant it, go to XFER.
  - If both eligible: grant the one that is not last_grant.
  - If none eligible: stay in ARB.
  - grant is registered; last_grant updates when the grant is made.
- State XFER:
  - Master outputs are driven combinationally from the granted requester's address, writedata, read and write.
  - granted rN_waitrequest = m_waitrequest. Non-granted waitrequest = 1.
  - When m_waitrequest=0, the transfer is accepted. If it is a read, push the grant ID into the FIFO. Return to ARB.
  - If the granted requester drops both read and write while in XFER (protocol violation), return to ARB without a transfer.
  - Sustained throughput is one transfer per 2 cycles minimum.
- Read return path (combinational routing):
  - On m_readdatavalid with FIFO non-empty, assert r{head}_readdatavalid for that cycle, with rN_readdata = m_readdata, then pop the FIFO.
  - Both rN_readdata buses always carry m_readdata; only readdatavalid is routed.
  - m_readdatavalid with FIFO empty: no requester valid asserted, err_unexpected_rdv set to 1 and held until reset.
- pending_count:
  - +1 on push, −1 on pop; unchanged on simultaneous push and pop.
  - Never exceeds MAX_PENDING, since reads are not granted at full.
  - Writes still proceed when the FIFO is full.
- Read ordering: returns are in issue order per the Avalon pipelined-read rule; the FIFO preserves requester order across interleaving.

Test Plan:
- After reset, r0 writes addr 0x0800000, data 0x00FF00FF, m_waitrequest=0 -> ARB then XFER; m_write=1 with that address and data in cycle 2; r0_waitrequest low in cycle 2 only.
- r0 and r1 both hold reads continuously, SDRAM returns each read 3 cycles after accept -> grants alternate 0,1,0,1; returned data routed in the same order; pending_count peaks at 2.
- MAX_PENDING=4, r1 issues 5 reads with no readdatavalid, then r0 issues a write -> 5th read stalls with r1_waitrequest=1 and pending_count=4; the r0 write is granted; after one readdatavalid the 5th read is accepted.
- m_waitrequest held high for 6 cycles during an r1 write -> m_address and m_writedata stable, r1_waitrequest=1 throughout; r0 is not granted until the r1 write is accepted.
- m_readdatavalid pulsed with no reads pending -> no rN_readdatavalid asserted; err_unexpected_rdv=1 and stays 1 until reset_n=0.
- reset_n low for one cycle with 2 reads pending -> pending_count=0 and m_read=0 on the next cycle; a later stray m_readdatavalid sets err_unexpected_rdv.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter for a single Avalon-MM SDRAM master port.
// Accepted read IDs are queued so returning readdatavalid beats reach their issuer.
module sdram_port_arbiter #(
    parameter int ADDRESSWIDTH = 26,
    parameter int DATAWIDTH    = 32,
    parameter int MAX_PENDING  = 4,
    localparam int PW = $clog2(MAX_PENDING),
    localparam int CW = PW + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic [ADDRESSWIDTH-1:0] r0_address,
    input  logic                    r0_write,
    input  logic                    r0_read,
    input  logic [DATAWIDTH-1:0]    r0_writedata,
    output logic                    r0_waitrequest,
    output logic [DATAWIDTH-1:0]    r0_readdata,
    output logic                    r0_readdatavalid,

    input  logic [ADDRESSWIDTH-1:0] r1_address,
    input  logic                    r1_write,
    input  logic                    r1_read,
    input  logic [DATAWIDTH-1:0]    r1_writedata,
    output logic                    r1_waitrequest,
    output logic [DATAWIDTH-1:0]    r1_readdata,
    output logic                    r1_readdatavalid,

    output logic [ADDRESSWIDTH-1:0] m_address,
    output logic                    m_write,
    output logic                    m_read,
    output logic [DATAWIDTH-1:0]    m_writedata,
    input  logic                    m_waitrequest,
    input  logic [DATAWIDTH-1:0]    m_readdata,
    input  logic                    m_readdatavalid,

    output logic [CW-1:0]           pending_count,
    output logic                    err_unexpected_rdv
);

    // state | meaning
    // ARB   | master idle, choosing the next requester
    // XFER  | granted requester drives the master port until accepted
    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    grant_q;
    logic                    last_grant_q;
    logic [CW-1:0]           pending_q;
    logic [CW-1:0]           pending_d;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [MAX_PENDING-1:0]  id_fifo_q;
    logic                    err_q;

    logic                    full;
    logic                    empty;
    logic                    elig0;
    logic                    elig1;
    logic                    xfer;
    logic                    g_write;
    logic                    g_read;
    logic [ADDRESSWIDTH-1:0] g_address;
    logic [DATAWIDTH-1:0]    g_writedata;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    head_id;

    assign full  = (pending_q == CW'(MAX_PENDING));
    assign empty = (pending_q == '0);

    // A read is only eligible while the ID FIFO has room; writes always are.
    assign elig0 = r0_write | (r0_read & ~full);
    assign elig1 = r1_write | (r1_read & ~full);

    assign xfer        = (state_q == XFER);
    assign g_write     = grant_q ? r1_write     : r0_write;
    assign g_read      = grant_q ? r1_read      : r0_read;
    assign g_address   = grant_q ? r1_address   : r0_address;
    assign g_writedata = grant_q ? r1_writedata : r0_writedata;

    // Write wins when a requester raises both strobes.
    assign m_write     = xfer & g_write;
    assign m_read      = xfer & g_read & ~g_write;
    assign m_address   = xfer ? g_address   : '0;
    assign m_writedata = xfer ? g_writedata : '0;

    assign r0_waitrequest = (xfer & ~grant_q) ? m_waitrequest : 1'b1;
    assign r1_waitrequest = (xfer &  grant_q) ? m_waitrequest : 1'b1;

    assign accept  = xfer & (g_write | g_read) & ~m_waitrequest;
    assign push    = accept & m_read;
    assign pop     = m_readdatavalid & ~empty;
    assign head_id = id_fifo_q[rd_ptr_q];

    assign r0_readdata      = m_readdata;
    assign r1_readdata      = m_readdata;
    assign r0_readdatavalid = pop & ~head_id;
    assign r1_readdatavalid = pop &  head_id;

    assign pending_count      = pending_q;
    assign err_unexpected_rdv = err_q;

    always_comb begin
        pending_d = pending_q;
        case ({push, pop})
            2'b10:   pending_d = pending_q + CW'(1);
            2'b01:   pending_d = pending_q - CW'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ARB;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ARB: begin
                    if (elig0 && elig1) begin
                        grant_q      <= ~last_grant_q;
                        last_grant_q <= ~last_grant_q;
                        state_q      <= XFER;
                    end else if (elig0) begin
                        grant_q      <= 1'b0;
                        last_grant_q <= 1'b0;
                        state_q      <= XFER;
                    end else if (elig1) begin
                        grant_q      <= 1'b1;
                        last_grant_q <= 1'b1;
                        state_q      <= XFER;
                    end
                end
                XFER: begin
                    // Dropping both strobes mid-grant abandons the slot.
                    if (accept || !(g_write || g_read)) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            id_fifo_q <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= grant_q;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            pending_q <= pending_d;
            if (m_readdatavalid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: writes, alternating reads,
// FIFO-full stall, long waitrequest, stray readdatavalid and mid-traffic reset.
module tb_sdram_port_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] r0_address, r1_address, m_address;
    logic          r0_write, r0_read, r1_write, r1_read;
    logic [DW-1:0] r0_writedata, r1_writedata, m_writedata;
    logic          r0_waitrequest, r1_waitrequest;
    logic [DW-1:0] r0_readdata, r1_readdata, m_readdata;
    logic          r0_readdatavalid, r1_readdatavalid;
    logic          m_write, m_read, m_waitrequest, m_readdatavalid;
    logic [CW-1:0] pending_count;
    logic          err_unexpected_rdv;

    int checks = 0;
    int errors = 0;

    // SDRAM read-latency model: returns each accepted read 3 cycles later.
    logic          resp_en;
    logic          p1v, p2v, p3v;
    logic [DW-1:0] p1d, p2d, p3d;

    sdram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .r0_address(r0_address), .r0_write(r0_write), .r0_read(r0_read),
        .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
        .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_write(r1_write), .r1_read(r1_read),
        .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
        .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
        .m_address(m_address), .m_write(m_write), .m_read(m_read),
        .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .pending_count(pending_count), .err_unexpected_rdv(err_unexpected_rdv)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic          acc;
        logic [DW-1:0] acc_d;
        acc   = resp_en && m_read && !m_waitrequest;
        acc_d = 32'hA5A50000 | DW'(m_address);
        @(posedge clk);
        #1;
        p3v = p2v; p3d = p2d;
        p2v = p1v; p2d = p1d;
        p1v = acc; p1d = acc_d;
        if (resp_en) begin
            m_readdatavalid = p3v;
            m_readdata      = p3d;
        end
    endtask

    task automatic rst();
        reset_n = 1'b0;
        r0_address = '0; r0_write = 0; r0_read = 0; r0_writedata = '0;
        r1_address = '0; r1_write = 0; r1_read = 0; r1_writedata = '0;
        m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
        resp_en = 0;
        p1v = 0; p2v = 0; p3v = 0; p1d = '0; p2d = '0; p3d = '0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rst_master", 64'({m_write, m_read, m_address, m_writedata}), 64'(0));
        check("rst_wait", 64'({r0_waitrequest, r1_waitrequest}), 64'(2'b11));
        check("rst_rdv", 64'({r0_readdatavalid, r1_readdatavalid}), 64'(0));
        check("rst_pending", 64'(pending_count), 64'(0));
        check("rst_err", 64'(err_unexpected_rdv), 64'(0));
    endtask

    int gseq[8];
    int rseq[8];
    int ng, nr, peak, cnt;

    initial begin
        // Single write from r0
        rst();
        r0_address = 26'h0800000; r0_writedata = 32'h00FF00FF; r0_write = 1;
        #1;
        check("w_c1_mwrite", 64'(m_write), 64'(0));
        check("w_c1_wait", 64'(r0_waitrequest), 64'(1));
        tick(); #1;
        check("w_c2_mwrite", 64'(m_write), 64'(1));
        check("w_c2_addr", 64'(m_address), 64'(26'h0800000));
        check("w_c2_data", 64'(m_writedata), 64'(32'h00FF00FF));
        check("w_c2_wait", 64'({r0_waitrequest, r1_waitrequest}), 64'(2'b01));
        tick(); r0_write = 0; #1;
        check("w_c3_wait", 64'(r0_waitrequest), 64'(1));
        check("w_c3_mwrite", 64'(m_write), 64'(0));

        // Both requesters read continuously, 3-cycle latency
        rst();
        resp_en = 1;
        r0_address = 26'h100; r1_address = 26'h200;
        r0_read = 1; r1_read = 1;
        ng = 0; nr = 0; peak = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 12) begin
                r0_read = 0; r1_read = 0;
            end
            #1;
            if (m_read && !m_waitrequest && ng < 8) begin
                gseq[ng] = r0_waitrequest ? 1 : 0;
                ng++;
            end
            if (r0_readdatavalid && r1_readdatavalid)
                check("rr_both_rdv", 64'(1), 64'(0));
            if (r0_readdatavalid && nr < 8) begin
                rseq[nr] = 0; nr++;
                check("rr_r0_data", 64'(r0_readdata), 64'(32'hA5A50100));
            end
            if (r1_readdatavalid && nr < 8) begin
                rseq[nr] = 1; nr++;
                check("rr_r1_data", 64'(r1_readdata), 64'(32'hA5A50200));
            end
            if (int'(pending_count) > peak) peak = int'(pending_count);
            tick();
        end
        check("rr_grant_cnt", 64'(ng), 64'(6));
        check("rr_ret_cnt", 64'(nr), 64'(6));
        for (int k = 0; k < 4; k++) begin
            check("rr_grant_order", 64'(gseq[k]), 64'(k % 2));
            check("rr_ret_order", 64'(rseq[k]), 64'(k % 2));
        end
        check("rr_peak", 64'(peak), 64'(2));
        #1;
        check("rr_drained", 64'(pending_count), 64'(0));

        // FIFO full: r1 reads stall, r0 write still goes through
        rst();
        r1_address = 26'h300; r1_read = 1;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            #1;
            if (m_read && !r1_waitrequest) cnt++;
            tick();
        end
        #1;
        check("full_accepts", 64'(cnt), 64'(4));
        check("full_pending", 64'(pending_count), 64'(4));
        for (int i = 0; i < 3; i++) begin
            check("full_stall", 64'({r1_waitrequest, m_read}), 64'(2'b10));
            tick(); #1;
        end
        r0_address = 26'h40; r0_writedata = 32'hCAFE0001; r0_write = 1;
        #1;
        check("full_w_arb", 64'(r0_waitrequest), 64'(1));
        tick(); #1;
        check("full_w_acc", 64'({r0_waitrequest, m_write, r1_waitrequest}), 64'(3'b011));
        check("full_w_addr", 64'(m_address), 64'(26'h40));
        check("full_w_pend", 64'(pending_count), 64'(4));
        tick(); r0_write = 0; #1;
        check("full_after_w", 64'({m_write, m_read, r1_waitrequest}), 64'(3'b001));
        m_readdatavalid = 1; m_readdata = 32'h12345678;
        #1;
        check("full_rdv_route", 64'({r0_readdatavalid, r1_readdatavalid}), 64'(2'b01));
        check("full_rdv_data", 64'(r1_readdata), 64'(32'h12345678));
        tick(); m_readdatavalid = 0; #1;
        check("full_pop_pend", 64'(pending_count), 64'(3));
        check("full_pop_wait", 64'(r1_waitrequest), 64'(1));
        tick(); #1;
        check("full_5th_acc", 64'({r1_waitrequest, m_read}), 64'(2'b01));
        tick(); r1_read = 0; #1;
        check("full_5th_pend", 64'(pending_count), 64'(4));

        // Long waitrequest during an r1 write
        rst();
        r1_address = 26'h1555555; r1_writedata = 32'hDEADBEEF; r1_write = 1;
        m_waitrequest = 1;
        #1;
        check("ws_arb", 64'(m_write), 64'(0));
        tick();
        r0_address = 26'h11; r0_writedata = 32'h11111111; r0_write = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("ws_hold_ctl", 64'({m_write, r1_waitrequest, r0_waitrequest}), 64'(3'b111));
            check("ws_hold_addr", 64'(m_address), 64'(26'h1555555));
            check("ws_hold_data", 64'(m_writedata), 64'(32'hDEADBEEF));
            tick();
        end
        m_waitrequest = 0;
        #1;
        check("ws_acc", 64'({r1_waitrequest, r0_waitrequest}), 64'(2'b01));
        tick(); r1_write = 0; #1;
        check("ws_r0_arb", 64'(r0_waitrequest), 64'(1));
        tick(); #1;
        check("ws_r0_acc", 64'(r0_waitrequest), 64'(0));
        check("ws_r0_addr", 64'(m_address), 64'(26'h11));
        tick(); r0_write = 0;

        // Stray readdatavalid with nothing pending
        rst();
        m_readdatavalid = 1;
        #1;
        check("stray_rdv", 64'({r0_readdatavalid, r1_readdatavalid}), 64'(0));
        tick(); m_readdatavalid = 0; #1;
        check("stray_err", 64'(err_unexpected_rdv), 64'(1));
        tick(); tick(); tick(); #1;
        check("stray_sticky", 64'(err_unexpected_rdv), 64'(1));
        rst();

        // Reset with two reads pending
        rst();
        r0_address = 26'h50; r0_read = 1;
        cnt = 0;
        for (int i = 0; i < 12 && cnt < 2; i++) begin
            #1;
            if (m_read && !r0_waitrequest) cnt++;
            tick();
        end
        r0_read = 0;
        #1;
        check("mr_accepts", 64'(cnt), 64'(2));
        check("mr_pending", 64'(pending_count), 64'(2));
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
        check("mr_pend_clr", 64'(pending_count), 64'(0));
        check("mr_mread", 64'(m_read), 64'(0));
        check("mr_err_clr", 64'(err_unexpected_rdv), 64'(0));
        m_readdatavalid = 1;
        #1;
        check("mr_lost_rdv", 64'({r0_readdatavalid, r1_readdatavalid}), 64'(0));
        tick(); m_readdatavalid = 0; #1;
        check("mr_err_set", 64'(err_unexpected_rdv), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
